// File: rtl/skolem_search_ctrl.sv
// Sequential search for the first 4-bit candidate x satisfying a fixed Boolean spec F(x,i).
// Optional build macro SKOLEM_WARM_START_EN: start each sweep at the last satisfying x_out.
module skolem_search_ctrl #(
  parameter int NCAND = 16,
  parameter int CW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [12:0]   i_vec,
  input  logic          abort,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          sat,
  output logic [3:0]    x_out,
  output logic [CW-1:0] iters
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t        state, state_nx;
  logic [12:0]   i_q;
  logic [3:0]    cand;
  logic [4:0]    count;
  logic          sat_q;
  logic [3:0]    x_q;
  logic [CW-1:0] iters_q;
  logic [3:0]    start_cand;
  logic          hit, last;

  // Bits 0,4,5,6 of the request vector carry no meaning for F.
  logic unused_bits;
  assign unused_bits = ^{i_q[0], i_q[6:4]};

  // cand = {x6,x5,x4,x0}
  logic x0, x4, x5, x6, c05, maj3;
  always_comb begin
    x0   = cand[0];
    x4   = cand[1];
    x5   = cand[2];
    x6   = cand[3];
    c05  = x0 & x5;
    maj3 = (x4 & x6) | (x4 & c05) | (x6 & c05);
    hit  = (i_q[7]  == (x0 ^ x5))
        && (i_q[8]  == (x4 ^ x6 ^ c05))
        && (i_q[3]  == maj3)
        && (i_q[1]  == ~i_q[9])
        && (i_q[10] == (x0 | i_q[12]))
        && (i_q[11] == (x4 & i_q[10]))
        && (i_q[12] == (x5 | i_q[11]));
    last = (count == 5'(NCAND - 1));
  end

`ifdef SKOLEM_WARM_START_EN
  logic [3:0] warm_q;
  always_ff @(posedge clk) begin
    if (!rst_n)
      warm_q <= 4'd0;
    else if (state == DONE && out_ready && sat_q)
      warm_q <= x_q;
  end
  assign start_cand = warm_q;
`else
  assign start_cand = 4'd0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // abort outranks a hit evaluated in the same cycle
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)        state_nx = SEARCH;
      SEARCH:  if (abort)           state_nx = IDLE;
               else if (hit || last) state_nx = DONE;
      DONE:    if (out_ready)       state_nx = IDLE;
      default:                      state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_q     <= '0;
      cand    <= '0;
      count   <= '0;
      sat_q   <= 1'b0;
      x_q     <= '0;
      iters_q <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          i_q   <= i_vec;
          cand  <= start_cand;
          count <= '0;
        end
        SEARCH: if (!abort) begin
          count <= count + 5'd1;
          if (hit) begin
            sat_q   <= 1'b1;
            x_q     <= cand;
            iters_q <= CW'(count + 5'd1);
          end else if (last) begin
            sat_q   <= 1'b0;
            x_q     <= '0;
            iters_q <= CW'(NCAND);
          end else begin
            cand <= cand + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sat       = sat_q;
  assign x_out     = x_q;
  assign iters     = iters_q;

endmodule

// File: tb/tb_skolem_search_ctrl.sv
// Vector table plus scoreboard bench for skolem_search_ctrl; handles both warm-start builds.
module tb_skolem_search_ctrl;
  localparam int CW = 5;
`ifdef SKOLEM_WARM_START_EN
  localparam bit WARM = 1'b1;
`else
  localparam bit WARM = 1'b0;
`endif

  logic          clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic [12:0]   i_vec = '0;
  logic          in_ready, out_valid, sat;
  logic [3:0]    x_out;
  logic [CW-1:0] iters;

  skolem_search_ctrl #(.NCAND(16), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .i_vec(i_vec),
    .abort(abort), .out_valid(out_valid), .out_ready(out_ready), .sat(sat),
    .x_out(x_out), .iters(iters)
  );

  always #5 clk = ~clk;

  typedef struct { logic [12:0] iv; logic sat; logic [3:0] x; int it; int hold; } vec_t;
  typedef struct { logic sat; logic [3:0] x; int it; } exp_t;

  exp_t sb[$];
  vec_t vt[8];
  int   errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, ".in_ready"},  32'(in_ready),  32'd1);
    chk({nm, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({nm, ".sat"},       32'(sat),       32'd0);
    chk({nm, ".x_out"},     32'(x_out),     32'd0);
    chk({nm, ".iters"},     32'(iters),     32'd0);
  endtask

  // Accept a request, wait for its response, compare against the scoreboard, then consume it.
  task automatic run_req(input string nm, input logic [12:0] iv, input exp_t e, input int hold);
    int   n;
    exp_t exp;
    logic s0; logic [3:0] x0; logic [CW-1:0] it0;
    chk({nm, ".idle"}, 32'(in_ready), 32'd1);
    i_vec = iv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    i_vec = 13'($urandom);
    sb.push_back(e);
    n = 1;
    while (!out_valid && n < 40) begin tick(); n++; end
    chk({nm, ".latency"}, 32'(n), 32'(e.it + 1));
    if (out_valid && sb.size() > 0) begin
      exp = sb.pop_front();
      chk({nm, ".sat"},   32'(sat),   32'(exp.sat));
      chk({nm, ".x_out"}, 32'(x_out), 32'(exp.x));
      chk({nm, ".iters"}, 32'(iters), 32'(exp.it));
    end
    s0 = sat; x0 = x_out; it0 = iters;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      tick();
      chk({nm, ".hold_valid"}, 32'(out_valid), 32'd1);
      chk({nm, ".hold_ready"}, 32'(in_ready),  32'd0);
      chk({nm, ".hold_data"},  32'({sat, x_out, iters}), 32'({s0, x0, it0}));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({nm, ".consumed"}, 32'({out_valid, in_ready}), 32'b01);
  endtask

  initial begin
    int   n;
    exp_t e;
    vt[0] = '{13'h0073, 1'b1, 4'h0, 1,  0};
    vt[1] = '{13'h0102, 1'b1, 4'h2, 3,  5};
    vt[2] = '{13'h0000, 1'b0, 4'h0, 16, 0};
    vt[3] = '{13'h000A, 1'b1, 4'hA, WARM ? 9 : 11, 0};
    vt[4] = '{13'h0002, 1'b1, 4'h0, WARM ? 7 : 1,  0};
    vt[5] = '{13'h1C8A, 1'b1, 4'hB, 12, 0};
    vt[6] = '{13'h0202, 1'b0, 4'h0, 16, 0};
    vt[7] = '{13'h0200, 1'b1, 4'h0, WARM ? 6 : 1,  0};

    tick(); tick();
    chk_reset("por");
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 8; k++) begin
      e = '{vt[k].sat, vt[k].x, vt[k].it};
      run_req($sformatf("vec%0d", k), vt[k].iv, e, vt[k].hold);
      tick();
    end

    // abort mid-search on an unsat request
    i_vec = 13'h0000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c < 5; c++) begin
      chk("abort.no_valid", 32'(out_valid), 32'd0);
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort.idle", 32'({out_valid, in_ready}), 32'b01);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("abort.quiet", 32'(out_valid), 32'd0);
    end
    chk("abort.sb_empty", 32'(sb.size()), 32'd0);

    // abort in the same cycle as a first-candidate hit
    i_vec = 13'h0002; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_hit.idle", 32'({out_valid, in_ready}), 32'b01);
    tick();
    chk("abort_hit.quiet", 32'(out_valid), 32'd0);

    run_req("post_abort", 13'h0102, '{1'b1, 4'h2, 3}, 0);
    tick();

    // reset while searching
    i_vec = 13'h0000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_reset("rst_search");
    tick();

    // reset while a response is pending
    run_req("pre_done", 13'h0102, '{1'b1, 4'h2, 3}, 0);
    tick();
    i_vec = 13'h000A; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 40) begin tick(); n++; end
    chk("rst_done.reached", 32'({out_valid, x_out}), 32'h1A);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_reset("rst_done");
    tick();

    // fresh behaviour after reset: start candidate back at 0
    run_req("post_rst", 13'h000A, '{1'b1, 4'hA, 11}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/skolem_search_ctrl.md
# skolem_search_ctrl

Sequential controller that sequences a fixed 4-output Boolean specification over a sweep of candidate assignments. For one latched input vector per request, it finds the first candidate that satisfies the specification, or reports that none exists. It sits between a request source (test harness or host) and the combinational specification evaluator, and exposes a valid/ready request port and a valid/ready response port.

## Interface
- NCAND, 16: candidates per search (2^4, fixed by the 4 x-variables; other values unsupported)
- CW, 5: width of iteration count output

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  request present
- in_ready  out  1  high only in IDLE
- i_vec  in  13  bit k = i_k for k in {1,2,3,7,8,9,10,11,12}; bits 0,4,5,6 ignored
- abort  in  1  cancel an in-progress search
- out_valid  out  1  response present
- out_ready  in  1  response consumed
- sat  out  1  a satisfying candidate was found
- x_out  out  4  {x_6,x_5,x_4,x_0} of the hit; 0 when unsat
- iters  out  CW  number of candidates evaluated, 1..16

## Operation
- The specification is F(x,i) = 1 iff all of the following hold:
  - i_7 = x0^x5
  - i_8 = x4^x6^(x0&x5)
  - i_3 = maj(x4, x6, x0&x5)
  - i_1 = ~i_9
  - i_10 = x0|i_12
  - i_11 = x4&i_10
  - i_12 = x5|i_11
- Candidate encoding: cand[3:0] = {x6,x5,x4,x0}.
- FSM states: IDLE, SEARCH, DONE.
  - IDLE: in_ready=1. On in_valid&in_ready, latch i_vec, set cand=start, count=0, go to SEARCH.
  - SEARCH: each cycle, evaluate F on the latched i and cand, then count++.
    - F=1: register sat=1, x_out=cand, iters=count+1, go to DONE.
    - Else, if count+1==16: register sat=0, x_out=0, iters=16, go to DONE.
    - Else: cand = cand+1 mod 16 (wraps 15→0).
  - DONE: out_valid=1. sat, x_out and iters are held stable until out_ready. On out_valid&out_ready, go to IDLE.
- abort:
  - In SEARCH: return to IDLE next cycle with no response.
  - In IDLE or DONE: ignored.
  - abort takes priority over a hit in the same cycle.
- Simultaneous events:
  - in_valid is not sampled outside IDLE.
  - A response handshake and a new request cannot share a cycle; IDLE is entered first.
- Reset (rst_n=0 at a clock edge, any state, including mid-search or with out_valid high):
  - state=IDLE, in_ready=1, out_valid=0, sat=0, x_out=0, iters=0, cand=0, count=0, warm-start register=0.

## Timing
- Accept edge = cycle 0. Candidate j (0-based in sweep order) is evaluated in cycle j+1.
- A hit on the j-th evaluated candidate asserts out_valid from cycle j+2.
- Unsat asserts out_valid at cycle 17.
- Minimum request-to-request spacing is 3 cycles (accept, one evaluation, DONE with out_ready=1), plus one IDLE cycle for the next accept.
- All outputs are registered. No combinational path exists from in_valid, out_ready or abort to any output.

## Configuration
- SKOLEM_WARM_START_EN:
  - Defined: the start candidate is the x_out of the most recent sat=1 response. It is updated when that response handshakes, is unchanged by unsat or aborted searches, and is reset to 0.
  - Undefined: start = 0 for every search, and the warm-start register is absent.
  - In both builds, each search still covers exactly 16 candidates with wrap-around.

## Test plan
- Reset, then i_1=1 with all other i bits 0 → out_valid at cycle 2, sat=1, x_out=4'h0, iters=1.
- Cold start, i_1=1, i_8=1, others 0 → out_valid at cycle 4, sat=1, x_out=4'h2, iters=3; hold out_ready=0 for 5 cycles → outputs stable, in_ready=0.
- i_1=0, i_9=0 → out_valid at cycle 17, sat=0, x_out=0, iters=16.
- After the x_out=2 response, request i_1=1, i_3=1, others 0 → x_out=4'hA; with SKOLEM_WARM_START_EN iters=9, without iters=11. Then (warm build) request i_1=1 only → sweep wraps 10..15,0 → x_out=0, iters=7.
- Unsat request with abort=1 at cycle 5 → no out_valid; in_ready=1 at cycle 6; the next request runs normally.
- Assert rst_n=0 during SEARCH and again during DONE with out_valid=1 → all outputs take their reset values next cycle; the next request behaves as after power-up.
